redirect_ctrl: RTL and testbench
================================

// Module: redirect_ctrl
// PURPOSE
//  Central PC-redirect sequencer between EX/ID control-flow sources and the fetch unit.
//  Arbitrates trap, EX branch-taken and ID jump requests, registers one redirect and
//  holds it until fetch accepts it. Drives per-stage flushes. Squashes wrong-path fetch
//  responses that are still in flight when the redirect is accepted.
// PARAMETERS
//  BUS_W         32  address width of targets and redirect PC
//  MAX_INFLIGHT  2   max outstanding fetch requests; sizes the inflight/squash counters
// PORTS
//  clk              in   1      clock
//  rst              in   1      reset, asynchronous, active-low
//  trapValid_i      in   1      trap/exception redirect request (EX)
//  trapTarget_i     in   BUS_W  trap vector
//  brTaken_i        in   1      conditional branch resolved taken (EX)
//  brTarget_i       in   BUS_W  branch target (PC+imm from ID/EX)
//  jmpValid_i       in   1      JAL/JALR decoded (ID)
//  jmpTarget_i      in   BUS_W  jump target (PC+imm or rs1+imm)
//  fetchReqFire_i   in   1      fetch request issued to imem this cycle
//  fetchRspValid_i  in   1      fetch response returned this cycle
//  redirReady_i     in   1      PC unit accepts redirect
//  redirValid_o     out  1      redirect pending
//  redirAddr_o      out  BUS_W  redirect target
//  flushIF_o        out  1      kill IF/ID register
//  flushID_o        out  1      kill ID/EX register
//  flushEX_o        out  1      kill EX/MEM register
//  dropRsp_o        out  1      discard current fetch response (wrong path)
//  busy_o           out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE. redirValid_o=0, redirAddr_o=0, inflight=0, squash=0.
//   All flush outputs, dropRsp_o and busy_o read 0.
//  Request priority: trap > branch > jump. Winner = highest valid input this cycle.
//  Flushes are combinational in the request cycle:
//   - trap: IF+ID+EX.
//   - branch: IF+ID.
//   - jump: IF only.
//  inflight counter:
//   - +1 on fetchReqFire_i, -1 on fetchRspValid_i, both -> unchanged.
//   - Saturates at 0 and MAX_INFLIGHT.
//   - Width $clog2(MAX_INFLIGHT+1).
//  States:
//   IDLE: winner present -> register target to redirAddr_o, redirValid_o=1 next cycle, -> PEND.
//   PEND: redirValid_o held, redirAddr_o stable.
//    - flushIF_o=1 every cycle; wrong-path fetches are killed.
//    - trapValid_i while the pending redirect is not a trap -> replace redirAddr_o with
//      trapTarget_i, assert IF+ID+EX that cycle.
//    - branch/jump in PEND are wrong-path: ignored, no flush beyond IF.
//    - redirValid_o & redirReady_i -> handshake:
//      squash <= inflight + fetchReqFire_i - fetchRspValid_i (clamped to 0..MAX_INFLIGHT);
//      redirValid_o <= 0; -> DRAIN if squash>0, else IDLE.
//   DRAIN: dropRsp_o = fetchRspValid_i. Each response decrements squash; 0 -> IDLE.
//    - New fetches in DRAIN are right-path; they count in inflight only.
//    - trapValid_i in DRAIN: accept as in IDLE (-> PEND), squash keeps counting down.
//    - Branch/jump in DRAIN: accept normally, flushes per priority.
//  Handshake and trap in the same cycle: the handshake completes with the old target.
//   The trap is then taken as a new request (-> PEND, next cycle).
//  Latency: request cycle N -> redirValid_o at N+1. Min 1 cycle in PEND if redirReady_i=1.
//  Async reset mid-PEND/DRAIN: the pending redirect is dropped and counters clear immediately.
//  busy_o = (state != IDLE).
// TESTING
//  1. IDLE, brTaken_i=1, brTarget_i=0x100, redirReady_i=1 -> flushIF/ID=1 same cycle;
//     next cycle redirValid_o=1, redirAddr_o=0x100; then IDLE.
//  2. jmpValid_i=1 (0x40) and brTaken_i=1 (0x80) same cycle -> addr=0x80, flushIF+ID.
//     flushEX_o=0.
//  3. PEND branch 0x80, redirReady_i=0 for 3 cycles, then trapValid_i (0x8) ->
//     redirAddr_o=0x8, flushIF/ID/EX=1 that cycle, addr held until ready.
//  4. Two fetches fired, none returned, redirect accepted -> DRAIN with squash=2.
//     Next 2 responses get dropRsp_o=1. Third response dropRsp_o=0; state IDLE.
//  5. Handshake cycle with fetchReqFire_i=1, inflight=1, fetchRspValid_i=1 -> squash=1.
//  6. Assert rst low while in PEND -> redirValid_o=0, busy_o=0 immediately.
//     After release, a fresh jump 0x200 redirects normally.

Source files
------------

// File: rtl/redirect_ctrl.sv
// PC-redirect sequencer: arbitrates trap/branch/jump redirects, holds one until fetch
// accepts it, drives stage flushes and squashes wrong-path fetch responses.
module redirect_ctrl #(
  parameter int BUS_W        = 32,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trapValid_i,
  input  logic [BUS_W-1:0] trapTarget_i,
  input  logic             brTaken_i,
  input  logic [BUS_W-1:0] brTarget_i,
  input  logic             jmpValid_i,
  input  logic [BUS_W-1:0] jmpTarget_i,
  input  logic             fetchReqFire_i,
  input  logic             fetchRspValid_i,
  input  logic             redirReady_i,
  output logic             redirValid_o,
  output logic [BUS_W-1:0] redirAddr_o,
  output logic             flushIF_o,
  output logic             flushID_o,
  output logic             flushEX_o,
  output logic             dropRsp_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [BUS_W-1:0] addr_q, addr_d;
  logic             is_trap_q, is_trap_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] squash_q, squash_d;

  logic             any_req;
  logic             handshake;
  logic             trap_take;
  logic [BUS_W-1:0] win_target;

  assign any_req    = trapValid_i | brTaken_i | jmpValid_i;
  assign win_target = trapValid_i ? trapTarget_i :
                      brTaken_i   ? brTarget_i   : jmpTarget_i;
  assign handshake  = (state_q == PEND) & redirReady_i;
  // A trap may override a pending non-trap; on a handshake it becomes a fresh request.
  assign trap_take  = (state_q == PEND) & trapValid_i & (~is_trap_q | redirReady_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      is_trap_q  <= 1'b0;
      inflight_q <= '0;
      squash_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      is_trap_q  <= is_trap_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (fetchReqFire_i && !fetchRspValid_i && inflight_q != MAX_CNT) begin
      inflight_d = inflight_q + ONE_CNT;
    end else if (fetchRspValid_i && !fetchReqFire_i && inflight_q != '0) begin
      inflight_d = inflight_q - ONE_CNT;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    is_trap_d = is_trap_q;
    squash_d  = squash_q;
    if (fetchRspValid_i && squash_q != '0) begin
      squash_d = squash_q - ONE_CNT;
    end
    case (state_q)
      IDLE, DRAIN: begin
        if (any_req) begin
          state_d   = PEND;
          addr_d    = win_target;
          is_trap_d = trapValid_i;
        end else if (state_q == DRAIN && squash_d == '0) begin
          state_d = IDLE;
        end
      end
      PEND: begin
        if (handshake) begin
          // Everything still outstanding at acceptance belongs to the old path.
          squash_d = inflight_d;
          if (trapValid_i) begin
            addr_d    = trapTarget_i;
            is_trap_d = 1'b1;
          end else if (inflight_d != '0) begin
            state_d = DRAIN;
          end else begin
            state_d = IDLE;
          end
        end else if (trap_take) begin
          addr_d    = trapTarget_i;
          is_trap_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flushIF_o = 1'b0;
    flushID_o = 1'b0;
    flushEX_o = 1'b0;
    case (state_q)
      IDLE, DRAIN: begin
        flushIF_o = any_req;
        flushID_o = trapValid_i | brTaken_i;
        flushEX_o = trapValid_i;
      end
      PEND: begin
        flushIF_o = 1'b1;
        flushID_o = trap_take;
        flushEX_o = trap_take;
      end
      default: begin
        flushIF_o = 1'b0;
        flushID_o = 1'b0;
        flushEX_o = 1'b0;
      end
    endcase
  end

  assign redirValid_o = (state_q == PEND);
  assign redirAddr_o  = addr_q;
  assign dropRsp_o    = fetchRspValid_i & (squash_q != '0);
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_redirect_ctrl.sv
// Self-checking bench for redirect_ctrl: directed vector table, hand-written corner
// sequences, then randomized traffic against a behavioural model.
module tb_redirect_ctrl;

  localparam int BUS_W   = 32;
  localparam int MAX_INF = 2;

  logic             clk;
  logic             rst;
  logic             trapValid, brTaken, jmpValid;
  logic [BUS_W-1:0] trapTarget, brTarget, jmpTarget;
  logic             reqFire, rspValid, ready;
  logic             redirValid, flushIF, flushID, flushEX, dropRsp, busy;
  logic [BUS_W-1:0] redirAddr;

  int checks = 0;
  int errors = 0;

  redirect_ctrl #(.BUS_W(BUS_W), .MAX_INFLIGHT(MAX_INF)) dut (
    .clk            (clk),
    .rst            (rst),
    .trapValid_i    (trapValid),
    .trapTarget_i   (trapTarget),
    .brTaken_i      (brTaken),
    .brTarget_i     (brTarget),
    .jmpValid_i     (jmpValid),
    .jmpTarget_i    (jmpTarget),
    .fetchReqFire_i (reqFire),
    .fetchRspValid_i(rspValid),
    .redirReady_i   (ready),
    .redirValid_o   (redirValid),
    .redirAddr_o    (redirAddr),
    .flushIF_o      (flushIF),
    .flushID_o      (flushID),
    .flushEX_o      (flushEX),
    .dropRsp_o      (dropRsp),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        trap;
    logic [31:0] trapT;
    logic        br;
    logic [31:0] brT;
    logic        jmp;
    logic [31:0] jmpT;
    logic        req;
    logic        rsp;
    logic        rdy;
    logic        eValid;
    logic [31:0] eAddr;
    logic        eIF;
    logic        eID;
    logic        eEX;
    logic        eDrop;
    logic        eBusy;
  } vec_t;

  vec_t vecs [15];

  // Behavioural model: pending redirect plus plain integer counters
  bit          mPend;
  logic [31:0] mAddr;
  bit          mIsTrap;
  int          mSquash;
  int          mInfl;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic t, input logic [31:0] tT, input logic b,
                               input logic [31:0] bT, input logic j, input logic [31:0] jT,
                               input logic rq, input logic rs, input logic rd);
    trapValid = t;  trapTarget = tT;
    brTaken   = b;  brTarget   = bT;
    jmpValid  = j;  jmpTarget  = jT;
    reqFire   = rq; rspValid   = rs; ready = rd;
  endtask

  task automatic idleInputs();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Checks outputs mid-cycle, then advances one clock
  task automatic checkOutput(input string tag, input logic eValid, input logic [31:0] eAddr,
                             input logic eIF, input logic eID, input logic eEX,
                             input logic eDrop, input logic eBusy);
    @(negedge clk);
    compare({tag, ".valid"}, {31'd0, redirValid}, {31'd0, eValid});
    compare({tag, ".addr"},  redirAddr, eAddr);
    compare({tag, ".fIF"},   {31'd0, flushIF}, {31'd0, eIF});
    compare({tag, ".fID"},   {31'd0, flushID}, {31'd0, eID});
    compare({tag, ".fEX"},   {31'd0, flushEX}, {31'd0, eEX});
    compare({tag, ".drop"},  {31'd0, dropRsp}, {31'd0, eDrop});
    compare({tag, ".busy"},  {31'd0, busy}, {31'd0, eBusy});
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    idleInputs();
    rst = 1'b0;
    #12;
    compare("rst.valid", {31'd0, redirValid}, 32'd0);
    compare("rst.addr",  redirAddr, 32'd0);
    compare("rst.busy",  {31'd0, busy}, 32'd0);
    compare("rst.drop",  {31'd0, dropRsp}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mPend = 0; mAddr = 0; mIsTrap = 0; mSquash = 0; mInfl = 0;
  endtask

  function automatic int clampInfl(input int v);
    if (v < 0) return 0;
    if (v > MAX_INF) return MAX_INF;
    return v;
  endfunction

  task automatic randomCycle(input int n);
    logic t, b, j, rq, rs, rd;
    logic eIF, eID, eEX, eDrop;
    bit   trapTake;
    int   newInfl;
    string tag;
    t  = ($urandom_range(9) == 0);
    b  = ($urandom_range(4) == 0);
    j  = ($urandom_range(4) == 0);
    rq = ($urandom_range(9) < 4);
    rs = ($urandom_range(9) < 4);
    rd = ($urandom_range(1) == 1);
    applyStimulus(t, $urandom, b, $urandom, j, $urandom, rq, rs, rd);
    trapTake = mPend && t && (!mIsTrap || rd);
    if (mPend) begin
      eIF = 1; eID = trapTake; eEX = trapTake;
    end else begin
      eIF = t | b | j; eID = t | b; eEX = t;
    end
    eDrop = rs && (mSquash > 0);
    tag = $sformatf("rnd%0d", n);
    @(negedge clk);
    compare({tag, ".valid"}, {31'd0, redirValid}, {31'd0, mPend});
    compare({tag, ".addr"},  redirAddr, mAddr);
    compare({tag, ".fIF"},   {31'd0, flushIF}, {31'd0, eIF});
    compare({tag, ".fID"},   {31'd0, flushID}, {31'd0, eID});
    compare({tag, ".fEX"},   {31'd0, flushEX}, {31'd0, eEX});
    compare({tag, ".drop"},  {31'd0, dropRsp}, {31'd0, eDrop});
    compare({tag, ".busy"},  {31'd0, busy}, {31'd0, (mPend || mSquash > 0)});
    @(posedge clk);
    newInfl = clampInfl(mInfl + int'(rq) - int'(rs));
    if (rs && mSquash > 0) mSquash--;
    if (mPend && rd) begin
      mSquash = newInfl;
      if (t) begin
        mAddr = trapTarget; mIsTrap = 1;
      end else begin
        mPend = 0;
      end
    end else if (trapTake) begin
      mAddr = trapTarget; mIsTrap = 1;
    end else if (!mPend && (t || b || j)) begin
      mPend   = 1;
      mAddr   = t ? trapTarget : (b ? brTarget : jmpTarget);
      mIsTrap = t;
    end
    mInfl = newInfl;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    #2;

    //          trap trapT br brT    jmp jmpT   req rsp rdy  val addr    IF ID EX drop busy
    vecs[0]  = '{0, 0,     0, 0,     0, 0,      0,  0,  0,   0, 32'h0,   0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0,     1, 32'h100, 0, 0,    0,  0,  1,   0, 32'h0,   1, 1, 0, 0, 0};
    vecs[2]  = '{0, 0,     0, 0,     0, 0,      0,  0,  1,   1, 32'h100, 1, 0, 0, 0, 1};
    vecs[3]  = '{0, 0,     1, 32'h80, 1, 32'h40, 0, 0,  0,   0, 32'h100, 1, 1, 0, 0, 0};
    vecs[4]  = '{0, 0,     0, 0,     0, 0,      1,  0,  0,   1, 32'h80,  1, 0, 0, 0, 1};
    vecs[5]  = '{0, 0,     0, 0,     0, 0,      1,  0,  0,   1, 32'h80,  1, 0, 0, 0, 1};
    vecs[6]  = '{0, 0,     0, 0,     0, 0,      0,  0,  1,   1, 32'h80,  1, 0, 0, 0, 1};
    vecs[7]  = '{0, 0,     0, 0,     0, 0,      0,  0,  0,   0, 32'h80,  0, 0, 0, 0, 1};
    vecs[8]  = '{0, 0,     0, 0,     0, 0,      0,  1,  0,   0, 32'h80,  0, 0, 0, 1, 1};
    vecs[9]  = '{0, 0,     0, 0,     0, 0,      0,  1,  0,   0, 32'h80,  0, 0, 0, 1, 1};
    vecs[10] = '{0, 0,     0, 0,     0, 0,      0,  1,  0,   0, 32'h80,  0, 0, 0, 0, 0};
    vecs[11] = '{0, 0,     0, 0,     1, 32'h44, 0,  0,  0,   0, 32'h80,  1, 0, 0, 0, 0};
    vecs[12] = '{0, 0,     1, 32'h90, 1, 32'h48, 0, 0,  0,   1, 32'h44,  1, 0, 0, 0, 1};
    vecs[13] = '{0, 0,     0, 0,     0, 0,      0,  0,  1,   1, 32'h44,  1, 0, 0, 0, 1};
    vecs[14] = '{0, 0,     0, 0,     0, 0,      0,  0,  0,   0, 32'h44,  0, 0, 0, 0, 0};

    doReset();

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].trap, vecs[i].trapT, vecs[i].br, vecs[i].brT, vecs[i].jmp,
                    vecs[i].jmpT, vecs[i].req, vecs[i].rsp, vecs[i].rdy);
      checkOutput($sformatf("vec%0d", i), vecs[i].eValid, vecs[i].eAddr, vecs[i].eIF,
                  vecs[i].eID, vecs[i].eEX, vecs[i].eDrop, vecs[i].eBusy);
    end

    // Trap overrides a stalled branch redirect
    applyStimulus(0, 0, 1, 32'h80, 0, 0, 0, 0, 0);
    checkOutput("trap.req", 0, 32'h44, 1, 1, 0, 0, 0);
    idleInputs();
    for (int i = 0; i < 3; i++) checkOutput($sformatf("trap.hold%0d", i), 1, 32'h80, 1, 0, 0, 0, 1);
    applyStimulus(1, 32'h8, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("trap.hit", 1, 32'h80, 1, 1, 1, 0, 1);
    idleInputs();
    checkOutput("trap.new0", 1, 32'h8, 1, 0, 0, 0, 1);
    checkOutput("trap.new1", 1, 32'h8, 1, 0, 0, 0, 1);
    ready = 1'b1;
    checkOutput("trap.acc", 1, 32'h8, 1, 0, 0, 0, 1);
    idleInputs();
    checkOutput("trap.idle", 0, 32'h8, 0, 0, 0, 0, 0);

    // Squash count taken from fire/response on the handshake cycle
    applyStimulus(0, 0, 0, 0, 1, 32'h10, 1, 0, 0);
    checkOutput("sq.req", 0, 32'h8, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1);
    checkOutput("sq.hs", 1, 32'h10, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("sq.drop", 0, 32'h10, 0, 0, 0, 1, 1);
    checkOutput("sq.keep", 0, 32'h10, 0, 0, 0, 0, 0);

    // Handshake coinciding with a trap: old target completes, trap becomes pending
    applyStimulus(0, 0, 1, 32'h120, 0, 0, 0, 0, 0);
    checkOutput("hst.req", 0, 32'h10, 1, 1, 0, 0, 0);
    applyStimulus(1, 32'h4, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("hst.hs", 1, 32'h120, 1, 1, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("hst.trap", 1, 32'h4, 1, 0, 0, 0, 1);
    idleInputs();
    checkOutput("hst.idle", 0, 32'h4, 0, 0, 0, 0, 0);

    // Asynchronous reset while a redirect is pending
    applyStimulus(0, 0, 1, 32'h300, 0, 0, 0, 0, 0);
    checkOutput("ar.req", 0, 32'h4, 1, 1, 0, 0, 0);
    idleInputs();
    #2;
    rst = 1'b0;
    #1;
    compare("ar.valid", {31'd0, redirValid}, 32'd0);
    compare("ar.busy",  {31'd0, busy}, 32'd0);
    compare("ar.addr",  redirAddr, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 32'h200, 0, 0, 1);
    checkOutput("ar.jmp", 0, 32'h0, 1, 0, 0, 0, 0);
    idleInputs();
    ready = 1'b1;
    checkOutput("ar.pend", 1, 32'h200, 1, 0, 0, 0, 1);
    idleInputs();
    checkOutput("ar.idle", 0, 32'h200, 0, 0, 0, 0, 0);

    doReset();
    for (int n = 0; n < 3000; n++) randomCycle(n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
